// File: rtl/frog_pkg.sv
// Shared types for the frog move path: direction codes and scheduler FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frog_pkg;

    localparam int NUM_DIRS = 4;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_COOLDOWN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/move_scheduler_rr_arbiter4.sv
// Four-way round-robin pick: highest priority is the direction after the last grant.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module rr_arbiter4
    import frog_pkg::*;
(
    input  logic [NUM_DIRS-1:0] i_req,
    input  logic [1:0]          i_last,
    output logic [1:0]          o_grant,
    output logic                o_any_req
);

    logic [1:0] w_idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        o_grant   = 2'd0;
        w_idx     = 2'd0;
        o_any_req = |i_req;
        for (int k = NUM_DIRS; k >= 1; k--) begin
            w_idx = i_last + 2'(k);
            if (i_req[w_idx]) begin
                o_grant = w_idx;
            end
        end
    end

endmodule

// File: rtl/move_scheduler.sv
// Collects direction pulses, arbitrates round-robin, offers one move at a time with a cooldown.
// Latency: pulse sampled at edge k -> o_move_valid after edge k+1; moves spaced >= COOLDOWN+2 cycles.
// Backpressure: offer held stable until i_move_ready; MOVE_OPPOSITE_CANCEL_EN drops opposing same-cycle pairs.
module move_scheduler
    import frog_pkg::*;
#(
    parameter int COOLDOWN = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_DIRS-1:0] i_btn_pulse,
    input  logic                i_game_active,
    input  logic                i_move_ready,
    output logic                o_move_valid,
    output logic [1:0]          o_move_dir,
    output logic                o_busy
);

    localparam int CNT_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    sched_state_t        r_state;
    logic [NUM_DIRS-1:0] r_pending;
    logic [1:0]          r_rr_last;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_move_valid;
    dir_t                r_move_dir;
    logic                r_busy;

    logic [NUM_DIRS-1:0] w_set;
    logic [NUM_DIRS-1:0] w_clr;
    logic                w_handshake;
    logic [1:0]          w_grant;
    logic                w_any_req;

    assign o_move_valid = r_move_valid;
    assign o_move_dir   = r_move_dir;
    assign o_busy       = r_busy;

    assign w_handshake = (r_state == S_ISSUE) && r_move_valid && i_move_ready;

    rr_arbiter4 u_arb (
        .i_req     (r_pending),
        .i_last    (r_rr_last),
        .o_grant   (w_grant),
        .o_any_req (w_any_req)
    );

    // New requests from this cycle's pulses, optionally dropping opposing pairs.
    always_comb begin
        w_set = i_btn_pulse;
`ifdef MOVE_OPPOSITE_CANCEL_EN
        if (i_btn_pulse[DIR_UP] && i_btn_pulse[DIR_DOWN]) begin
            w_set[DIR_UP]   = 1'b0;
            w_set[DIR_DOWN] = 1'b0;
        end
        if (i_btn_pulse[DIR_LEFT] && i_btn_pulse[DIR_RIGHT]) begin
            w_set[DIR_LEFT]  = 1'b0;
            w_set[DIR_RIGHT] = 1'b0;
        end
`endif
    end

    // The direction just transferred is retired from the pending set.
    always_comb begin
        w_clr = '0;
        if (w_handshake) begin
            w_clr[r_move_dir] = 1'b1;
        end
    end

    // Pending flags: clear first, then set, so a same-edge repeat press survives.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending <= '0;
        end else if (!i_game_active) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
        end
    end

    // Scheduler FSM with registered valid/dir/busy; a flush overrides every state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_rr_last    <= 2'd3;
            r_cnt        <= '0;
            r_move_valid <= 1'b0;
            r_move_dir   <= DIR_UP;
            r_busy       <= 1'b0;
        end else if (!i_game_active) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_move_valid <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= S_ISSUE;
                        r_move_dir   <= dir_t'(w_grant);
                        r_move_valid <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_handshake) begin
                        r_move_valid <= 1'b0;
                        r_rr_last    <= r_move_dir;
                        if (COOLDOWN == 0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_COOLDOWN;
                            r_cnt   <= CNT_W'(COOLDOWN);
                        end
                    end
                end
                S_COOLDOWN: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_move_valid <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/move_scheduler.md
Name: move_scheduler

Overview:
- Sits between the four per-button edge detectors and the frog position datapath.
- Collects one-cycle direction pulses (up/down/left/right) into pending flags and arbitrates them round-robin.
- Issues one move at a time to the datapath over a valid/ready handshake.
- Enforces a fixed cooldown between accepted moves, so simultaneous or rapid presses are serialised rather than lost or merged.

Parameters:
- COOLDOWN, 4, idle cycles after each accepted move before the next move may issue (0 = none).

Ports:
- clock  input  1  single system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; 0 = reset
- btn_pulse  input  4  one-cycle edge pulses; bit index = direction code (0 up, 1 down, 2 left, 3 right)
- game_active  input  1  level; 0 flushes all pending moves
- move_ready  input  1  datapath can accept a move this cycle
- move_valid  output  1  registered; move_dir is valid
- move_dir  output  2  registered direction code of the offered move
- busy  output  1  registered; high in ISSUE or COOLDOWN

Behaviour:
- Reset values (reset = 0, asynchronous):
  - state = IDLE
  - pending = 0000
  - rr_last = 3 (up has first priority after reset)
  - cnt = 0
  - move_valid = 0, move_dir = 00, busy = 0
- Pending flags:
  - pending[i] sets on the edge where btn_pulse[i] = 1 and game_active = 1.
  - A repeat pulse on an already-pending direction is a no-op; there is no counting.
  - pending[i] clears on the handshake edge that transfers direction i.
  - If set and clear hit the same bit on the same edge, set wins and the bit stays pending.
- Arbitration:
  - Round-robin starting at (rr_last+1) mod 4.
  - Evaluated combinationally from registered pending in IDLE only.
- FSM states: IDLE, ISSUE, COOLDOWN.
  - IDLE: if game_active and pending != 0, go to ISSUE on the next edge, latching the winner into move_dir and setting move_valid = 1.
  - Latency: a pulse sampled at edge k gives move_valid high after edge k+1.
  - ISSUE: hold move_valid and move_dir stable until move_valid & move_ready.
    - On the handshake edge: clear pending[move_dir], set rr_last = move_dir, drop move_valid.
    - Then go to COOLDOWN with cnt = COOLDOWN, or to IDLE if COOLDOWN = 0.
  - COOLDOWN: cnt decrements each edge; at cnt = 1, return to IDLE on the next edge. Pulses arriving during COOLDOWN still set pending.
- Handshake rules:
  - move_dir never changes while move_valid = 1.
  - move_valid may only fall after a handshake, or on a flush.
- Flush (game_active = 0, any state): on the next edge pending = 0, state = IDLE, move_valid = 0, busy = 0, cnt = 0. This is the sole exception to the valid-hold rule.
- Back-to-back transfer is impossible by design: the minimum spacing between accepted moves is COOLDOWN+2 cycles.
- Width rule: cnt is $clog2(COOLDOWN+1) bits, minimum 1.
- rr_last wraps 3 → 0 with modulo-4 arithmetic.
- busy = 1 whenever state != IDLE.

Optional Feature:
- Macro: MOVE_OPPOSITE_CANCEL_EN
- Defined: if btn_pulse has both up and down set, or both left and right set, in the same cycle, neither bit of that pair is set in pending. Existing pending bits are unaffected.
- Undefined: both bits of the pair set normally and are served in round-robin order.

Decomposition:
- Package frog_pkg holds:
  - typedef enum logic [1:0] dir_t {DIR_UP = 0, DIR_DOWN = 1, DIR_LEFT = 2, DIR_RIGHT = 3}
  - FSM state enum sched_state_t {S_IDLE, S_ISSUE, S_COOLDOWN}
  - localparam NUM_DIRS = 4
- One natural sub-module: rr_arbiter4.
  - Inputs: 4-bit request, 2-bit last grant.
  - Outputs: grant index, any_req.
  - Purely combinational.
  - Instantiated once.

Test Plan:
- Single press: btn_pulse = 0001 at cycle 10, move_ready = 1 → move_valid = 1, move_dir = 0 at cycle 12, handshake at 12, busy high through cycle 16, idle at 17.
- Simultaneous press: btn_pulse = 1100 once, move_ready = 1, COOLDOWN = 4 → moves issue as dir 2 then dir 3, spaced 6 cycles apart; pending = 0000 afterwards.
- Backpressure: move_ready = 0 for 5 cycles after move_valid rises → move_dir stays constant, move_valid stays 1; transfer occurs on the first cycle move_ready = 1.
- Flush: pending = 1010 in COOLDOWN, game_active = 0 for 1 cycle → next cycle pending = 0000, state IDLE, move_valid = 0, no move issues afterwards.
- Async reset: assert reset = 0 mid-ISSUE between clock edges → move_valid = 0 and busy = 0 immediately, without waiting for an edge. After release, a btn_pulse = 1111 press is granted up first.
- Opposite cancel, macro defined: btn_pulse = 0011 → no move issues. Macro undefined: up then down issue.
